// File: rtl/regfile_pkg.sv
// Shared types, defaults and the clear-value helper for the multi-port register file.
package regfile_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int DEPTH_DEF = 32;

  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    READY = 1'b1
  } rf_state_e;

  // Value loaded into entry idx by the clear sequencer; entry 0 is always zero.
  function automatic logic [31:0] init_val(input int unsigned idx, input int unsigned mode);
    logic [31:0] v;
    case (mode)
      32'd1:   v = (idx == 32'd0) ? 32'd0 : idx;
      default: v = 32'd0;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/regfile_clear_fsm.sv
// Clear sequencer: walks entries 1..DEPTH-1 after reset or clr_req, emitting one write per cycle.
module regfile_clear_fsm
  import regfile_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_clr_req,
  output logic          o_busy,
  output logic          o_clr_we,
  output logic [AW-1:0] o_clr_addr
);

  localparam logic [AW-1:0] LAST_IDX  = AW'(DEPTH - 1);
  localparam logic [AW-1:0] FIRST_IDX = AW'(1);

  rf_state_e     r_state;
  rf_state_e     w_state_nxt;
  logic [AW-1:0] r_clr_ptr;
  logic [AW-1:0] w_ptr_nxt;
  logic          r_busy;

  // State, pointer and busy flag; busy is registered from the next state so it lines up with r_state.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state   <= CLEAR;
      r_clr_ptr <= FIRST_IDX;
      r_busy    <= 1'b1;
    end else begin
      r_state   <= w_state_nxt;
      r_clr_ptr <= w_ptr_nxt;
      r_busy    <= (w_state_nxt == CLEAR);
    end
  end

  // Next-state: CLEAR runs until the last entry is written; READY accepts a new clear request.
  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_clr_ptr;
    case (r_state)
      CLEAR: begin
        if (r_clr_ptr == LAST_IDX) begin
          w_state_nxt = READY;
          w_ptr_nxt   = FIRST_IDX;
        end else begin
          w_ptr_nxt   = r_clr_ptr + AW'(1);
        end
      end
      READY: begin
        if (i_clr_req) begin
          w_state_nxt = CLEAR;
          w_ptr_nxt   = FIRST_IDX;
        end else begin
          w_state_nxt = READY;
        end
      end
      default: begin
        w_state_nxt = CLEAR;
        w_ptr_nxt   = FIRST_IDX;
      end
    endcase
  end

  assign o_busy     = r_busy;
  assign o_clr_we   = r_busy;
  assign o_clr_addr = r_clr_ptr;

endmodule

// File: rtl/regfile_mp.sv
// Multi-read-port register file with hardwired-zero entry 0 and a clear sequencer.
// Optional REGFILE_BYPASS_EN: same-cycle write-through from the write port to matching read ports.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int  XLEN      = XLEN_DEF,
  parameter int  DEPTH     = DEPTH_DEF,
  parameter int  NUM_RD    = 2,
  parameter int  INIT_MODE = 1,
  localparam int AW        = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clr_req,
  output logic                   busy,
  input  logic [NUM_RD*AW-1:0]   rd_addr,
  output logic [NUM_RD*XLEN-1:0] rd_data,
  input  logic                   wr_en,
  input  logic [AW-1:0]          wr_addr,
  input  logic [XLEN-1:0]        wr_data
);

  logic [XLEN-1:0] r_mem [DEPTH];

  logic            w_busy;
  logic            w_clr_we;
  logic [AW-1:0]   w_clr_addr;
  logic            w_we;
  logic [AW-1:0]   w_waddr;
  logic [XLEN-1:0] w_wdata;
  logic            w_user_we;

  regfile_clear_fsm #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_clear_fsm (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_clr_req  (clr_req),
    .o_busy     (w_busy),
    .o_clr_we   (w_clr_we),
    .o_clr_addr (w_clr_addr)
  );

  assign busy      = w_busy;
  assign w_user_we = wr_en && (wr_addr != {AW{1'b0}});

  // Clear writes own the port while busy; user writes are dropped then.
  always_comb begin
    w_we    = 1'b0;
    w_waddr = {AW{1'b0}};
    w_wdata = {XLEN{1'b0}};
    if (w_clr_we) begin
      w_we    = 1'b1;
      w_waddr = w_clr_addr;
      w_wdata = XLEN'(init_val(32'(w_clr_addr), 32'(INIT_MODE)));
    end else if (w_user_we) begin
      w_we    = 1'b1;
      w_waddr = wr_addr;
      w_wdata = wr_data;
    end else begin
      w_we    = 1'b0;
    end
  end

  // Storage array; deliberately not reset, the clear sequencer initialises it.
  always_ff @(posedge clk) begin
    if (w_we) begin
      r_mem[w_waddr] <= w_wdata;
    end
  end

  for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
    logic [AW-1:0]   w_ra;
    logic [XLEN-1:0] w_rdat;

    assign w_ra = rd_addr[g*AW +: AW];

    // Read mux: busy and entry 0 force zero ahead of any stored or forwarded data.
    always_comb begin
      w_rdat = {XLEN{1'b0}};
      if (w_busy || (w_ra == {AW{1'b0}})) begin
        w_rdat = {XLEN{1'b0}};
`ifdef REGFILE_BYPASS_EN
      end else if (w_user_we && (w_ra == wr_addr)) begin
        w_rdat = wr_data;
`endif
      end else begin
        w_rdat = r_mem[w_ra];
      end
    end

    assign rd_data[g*XLEN +: XLEN] = w_rdat;
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp: a 32x32 two-port instance and a 16x64 four-port instance.
module tb_regfile_mp;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic         clr_req_a = 1'b0;
  logic         busy_a;
  logic [9:0]   rd_addr_a = 10'd0;
  logic [63:0]  rd_data_a;
  logic         wr_en_a   = 1'b0;
  logic [4:0]   wr_addr_a = 5'd0;
  logic [31:0]  wr_data_a = 32'd0;

  logic         clr_req_b = 1'b0;
  logic         busy_b;
  logic [15:0]  rd_addr_b = 16'd0;
  logic [255:0] rd_data_b;
  logic         wr_en_b   = 1'b0;
  logic [3:0]   wr_addr_b = 4'd0;
  logic [63:0]  wr_data_b = 64'd0;

  regfile_mp #(.XLEN(32), .DEPTH(32), .NUM_RD(2), .INIT_MODE(1)) dut_a (
    .clk(clk), .rst(rst), .clr_req(clr_req_a), .busy(busy_a),
    .rd_addr(rd_addr_a), .rd_data(rd_data_a[63:0]),
    .wr_en(wr_en_a), .wr_addr(wr_addr_a), .wr_data(wr_data_a)
  );

  regfile_mp #(.XLEN(64), .DEPTH(16), .NUM_RD(4), .INIT_MODE(1)) dut_b (
    .clk(clk), .rst(rst), .clr_req(clr_req_b), .busy(busy_b),
    .rd_addr(rd_addr_b), .rd_data(rd_data_b),
    .wr_en(wr_en_b), .wr_addr(wr_addr_b), .wr_data(wr_data_b)
  );

  typedef struct {
    string       tag;
    int          dsel;
    int          port;
    logic [63:0] exp;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] m_a [32];
  logic [63:0] m_b [16];
  int          n_cmp = 0;
  int          n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_init();
    for (int k = 0; k < 32; k++) m_a[k] = 32'(k);
    for (int k = 0; k < 16; k++) m_b[k] = 64'(k);
  endtask

  function automatic logic [63:0] act(input int dsel, input int port);
    if (dsel == 0) return {32'd0, rd_data_a[port*32 +: 32]};
    else           return rd_data_b[port*64 +: 64];
  endfunction

  // Drive a read address and queue the value that port must show this cycle.
  task automatic exp_rd(input string tag, input int dsel, input int port, input int addr,
                        input logic [63:0] exp);
    exp_t e;
    if (dsel == 0) rd_addr_a[port*5 +: 5] = 5'(addr);
    else           rd_addr_b[port*4 +: 4] = 4'(addr);
    e.tag = tag; e.dsel = dsel; e.port = port; e.exp = exp;
    sb_q.push_back(e);
  endtask

  // Compare queued reads at the negedge, then let the edge commit and mirror writes in the model.
  task automatic cycle();
    exp_t e;
    @(negedge clk);
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk(e.tag, act(e.dsel, e.port), e.exp);
    end
    @(posedge clk);
    if (wr_en_a && wr_addr_a != 5'd0) m_a[wr_addr_a] = wr_data_a;
    if (wr_en_b && wr_addr_b != 4'd0) m_b[wr_addr_b] = wr_data_b;
    #1;
    wr_en_a = 1'b0;
    wr_en_b = 1'b0;
  endtask

  // Count negedges with busy high on both instances; optionally pulse clr_req_a mid-sequence.
  task automatic wait_clear(input string tag, input int pulse_at, input bit chk_rd);
    int ca = 0;
    int cb = 0;
    bit da = 1'b0;
    bit db = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (!da) begin
        if (busy_a) begin
          ca++;
          if (chk_rd) chk({tag, "_rd_busy_a"}, rd_data_a, 64'd0);
        end else begin
          da = 1'b1;
        end
      end
      if (!db) begin
        if (busy_b) begin
          cb++;
          if (chk_rd) chk({tag, "_rd_busy_b"}, 64'(|rd_data_b), 64'd0);
        end else begin
          db = 1'b1;
        end
      end
      clr_req_a = (k == pulse_at);
      if (da && db) break;
    end
    clr_req_a = 1'b0;
    chk({tag, "_done"}, 64'(da && db), 64'd1);
    chk({tag, "_busy_cycles_a"}, 64'(ca), 64'd31);
    chk({tag, "_busy_cycles_b"}, 64'(cb), 64'd15);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    model_init();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy_a", 64'(busy_a), 64'd1);
    chk("rst_busy_b", 64'(busy_b), 64'd1);
    chk("rst_rd_a", rd_data_a, 64'd0);
    rst = 1'b0;
    wait_clear("init", -1, 1'b0);
    @(posedge clk); #1;

    // Post-clear init values, distinct addresses on all ports.
    exp_rd("t1_x5", 0, 0, 5, 64'd5);
    exp_rd("t1_x10", 0, 1, 10, 64'd10);
    exp_rd("t6_p0", 1, 0, 3, m_b[3]);
    exp_rd("t6_p1", 1, 1, 7, m_b[7]);
    exp_rd("t6_p2", 1, 2, 11, m_b[11]);
    exp_rd("t6_p3", 1, 3, 15, m_b[15]);
    cycle();

    wr_en_a = 1'b1; wr_addr_a = 5'd15; wr_data_a = 32'd42;
    exp_rd("t2_x6", 0, 0, 6, 64'(m_a[6]));
    exp_rd("t2_x31", 0, 1, 31, 64'(m_a[31]));
    cycle();
    exp_rd("t2_x15", 0, 0, 15, 64'd42);
    exp_rd("t2_x15_p1", 0, 1, 15, 64'd42);
    cycle();

    wr_en_a = 1'b1; wr_addr_a = 5'd0; wr_data_a = 32'd7;
    exp_rd("t2_x0_same", 0, 0, 0, 64'd0);
    exp_rd("t2_x0_same_p1", 0, 1, 0, 64'd0);
    cycle();
    exp_rd("t2_x0_after", 0, 0, 0, 64'd0);
    cycle();

    wr_en_a = 1'b1; wr_addr_a = 5'd12; wr_data_a = 32'd100;
    exp_rd("t3_x15", 0, 0, 15, 64'd42);
`ifdef REGFILE_BYPASS_EN
    exp_rd("t3_bypass_x12", 0, 1, 12, 64'd100);
`else
    exp_rd("t3_nobypass_x12", 0, 1, 12, 64'd12);
`endif
    cycle();
    exp_rd("t3_x12_p0", 0, 0, 12, 64'd100);
    exp_rd("t3_x12_p1", 0, 1, 12, 64'd100);
    cycle();

    wr_en_b = 1'b1; wr_addr_b = 4'd9; wr_data_b = 64'hCAFE_F00D_1234_5678;
    for (int p = 0; p < 4; p++) begin
`ifdef REGFILE_BYPASS_EN
      exp_rd("t6_same_cyc_x9", 1, p, 9, 64'hCAFE_F00D_1234_5678);
`else
      exp_rd("t6_same_cyc_x9", 1, p, 9, 64'd9);
`endif
    end
    cycle();
    for (int p = 0; p < 4; p++) exp_rd("t6_ident_x9", 1, p, 9, m_b[9]);
    cycle();
    wr_en_b = 1'b1; wr_addr_b = 4'd0; wr_data_b = {64{1'b1}};
    exp_rd("t6_x0_same", 1, 0, 0, 64'd0);
    exp_rd("t6_x1", 1, 1, 1, 64'd1);
    cycle();
    exp_rd("t6_x0_after", 1, 0, 0, 64'd0);
    cycle();

    wr_en_a = 1'b1; wr_addr_a = 5'd3; wr_data_a = 32'hDEAD_BEEF;
    cycle();
    exp_rd("t4_x3_pre", 0, 0, 3, 64'h0000_0000_DEAD_BEEF);
    cycle();

    // Clear request together with a write; then writes held during busy must be dropped.
    clr_req_a = 1'b1; clr_req_b = 1'b1;
    wr_en_a = 1'b1; wr_addr_a = 5'd20; wr_data_a = 32'h55;
    rd_addr_a = {5'd4, 5'd3};
    @(posedge clk); #1;
    clr_req_a = 1'b0; clr_req_b = 1'b0;
    wr_addr_a = 5'd4; wr_data_a = 32'h1234;
    wait_clear("t4", -1, 1'b1);
    wr_en_a = 1'b0;
    model_init();
    @(posedge clk); #1;
    exp_rd("t4_x3_post", 0, 0, 3, 64'd3);
    exp_rd("t4_x4_post", 0, 1, 4, 64'd4);
    cycle();
    exp_rd("t4_x20_post", 0, 0, 20, 64'd20);
    exp_rd("t4_x12_post", 0, 1, 12, 64'd12);
    for (int p = 0; p < 4; p++) exp_rd("t4_b_x9_post", 1, p, 9, 64'd9);
    cycle();

    // Reset partway through a clear, then a redundant clr_req while busy.
    clr_req_a = 1'b1;
    @(posedge clk); #1;
    clr_req_a = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("t5_busy_pre", 64'(busy_a), 64'd1);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    #2;
    chk("t5_rst_busy_a", 64'(busy_a), 64'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    wait_clear("t5", 5, 1'b0);
    model_init();
    @(posedge clk); #1;
    exp_rd("t5_x5", 0, 0, 5, 64'd5);
    exp_rd("t5_x10", 0, 1, 10, 64'd10);
    exp_rd("t5_b_p0", 1, 0, 0, 64'd0);
    exp_rd("t5_b_p1", 1, 1, 1, 64'd1);
    exp_rd("t5_b_p2", 1, 2, 14, 64'd14);
    exp_rd("t5_b_p3", 1, 3, 15, 64'd15);
    cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
